// File: rtl/uart_loader_pkg.sv
// uart_loader_pkg: frame byte constants and loader FSM states
package uart_loader_pkg;
  localparam logic [7:0] SYNC_BYTE = 8'h55;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_RUN   = 8'h02;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;
  typedef enum logic [2:0] {IDLE, CMD, ADDR0, ADDR1, CNT, DATA, CSUM, RESP} state_t;
endpackage

// File: rtl/uart_word_asm.sv
// uart_word_asm: packs four bytes LSB-first into a word, pulsing word_valid the cycle after the 4th
module uart_word_asm (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        last,
  output logic        word_valid,
  output logic [31:0] word
);
  logic [1:0] idx;
  assign last = idx == 2'd3;
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      idx        <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= byte_valid && last;
      if (byte_valid) begin
        idx  <= idx + 2'd1;
        word <= {byte_in, word[31:8]};
      end
    end
  end
endmodule

// File: rtl/uart_loader.sv
// uart_loader: parses WRITE/RUN frames from the UART, writes memory words and releases the CPU
import uart_loader_pkg::*;
module uart_loader #(
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              err_pulse
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_t            state, state_n;
  logic [7:0]        csum, cnt, addr_lo, resp;
  logic [ADDR_W-1:0] addr;
  logic [TW-1:0]     tcnt;
  logic              run, active, timeout, take, last, word_valid;
  logic [31:0]       word;
  assign active    = state != IDLE && state != RESP;
  assign timeout   = active && tcnt == TW'(TIMEOUT_CYCLES);
  assign take      = rx_valid && !timeout;
  assign mem_we    = word_valid;
  assign mem_addr  = addr;
  assign mem_wdata = word;
  uart_word_asm u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (state == IDLE && rx_valid && rx_data == SYNC_BYTE),
    .byte_valid (state == DATA && take),
    .byte_in    (rx_data),
    .last       (last),
    .word_valid (word_valid),
    .word       (word)
  );
  always_comb begin
    state_n = state;
    resp    = NAK_BYTE;
    if (timeout) state_n = IDLE;
    else case (state)
      IDLE:  state_n = rx_valid && rx_data == SYNC_BYTE ? CMD : IDLE;
      CMD:   state_n = !rx_valid ? CMD : rx_data == CMD_WRITE ? ADDR0 : rx_data == CMD_RUN ? CSUM : RESP;
      ADDR0: state_n = rx_valid ? ADDR1 : ADDR0;
      ADDR1: state_n = rx_valid ? CNT : ADDR1;
      CNT:   state_n = !rx_valid ? CNT : rx_data == 8'd0 ? CSUM : DATA;
      DATA:  state_n = rx_valid && last && cnt == 8'd1 ? CSUM : DATA;
      CSUM: begin
        state_n = rx_valid ? RESP : CSUM;
        resp    = rx_data == csum ? ACK_BYTE : NAK_BYTE;
      end
      RESP:  state_n = tx_busy ? RESP : IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tx_data   <= '0;
      tx_start  <= 1'b0;
      err_pulse <= 1'b0;
      cpu_hold  <= 1'b1;
      csum      <= '0;
      cnt       <= '0;
      run       <= 1'b0;
      addr_lo   <= '0;
      addr      <= '0;
      tcnt      <= '0;
    end else begin
      state     <= state_n;
      tx_start  <= state == RESP && !tx_busy;
      err_pulse <= timeout || (state == RESP && !tx_busy && tx_data == NAK_BYTE);
      tcnt      <= (!active || rx_valid) ? '0 : tcnt + 1'b1;
      if (state_n == RESP && state != RESP) tx_data <= resp;
      if (state == IDLE) begin
        csum <= '0;
        run  <= 1'b0;
      end else if (take && state inside {CMD, ADDR0, ADDR1, CNT, DATA}) csum <= csum ^ rx_data;
      if (take && state == CMD) run <= rx_data == CMD_RUN;
      if (take && state == ADDR0) addr_lo <= rx_data;
      if (take && state == ADDR1) addr <= ADDR_W'({rx_data, addr_lo});
      if (word_valid) addr <= addr + 1'b1;
      if (take && state == CNT) cnt <= rx_data;
      if (take && state == DATA && last) cnt <= cnt - 8'd1;
      if (take && state == CSUM && run && rx_data == csum) cpu_hold <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: directed frames against uart_loader with hand-computed writes and responses
module tb_uart_loader;
  localparam int TO = 200;
  logic        clk = 0, rst = 1, rx_valid = 0, tx_busy = 0;
  logic [7:0]  rx_data = 0, tx_data;
  logic        tx_start, mem_we, cpu_hold, err_pulse;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [15:0] wa[$];
  logic [31:0] wd[$];
  logic [7:0]  txq[$], f[$];
  int tests = 0, fails = 0, errs = 0, busy_viol = 0;
  uart_loader #(.ADDR_W(16), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .err_pulse(err_pulse)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (!rst) begin
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
    if (tx_start) begin
      txq.push_back(tx_data);
      if (tx_busy) busy_viol++;
    end
    if (err_pulse) errs++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic send_f();
    foreach (f[i]) begin
      @(posedge clk); #1;
      rx_data = f[i];
      rx_valid = 1;
      @(posedge clk); #1;
      rx_valid = 0;
    end
  endtask
  task automatic clear();
    wa.delete(); wd.delete(); txq.delete(); errs = 0;
  endtask
  task automatic settle();
    repeat (10) @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst tx_start", tx_start, 0);
    chk("rst tx_data", tx_data, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst cpu_hold", cpu_hold, 1);
    chk("rst err_pulse", err_pulse, 0);
    @(posedge clk); #1 rst = 0;
    f = '{8'h55, 8'h01, 8'h10, 8'h00, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h39};
    clear(); send_f(); settle();
    chk("t1 nwr", wa.size(), 2);
    chk("t1 a0", wa[0], 16'h0010);
    chk("t1 d0", wd[0], 32'h12345678);
    chk("t1 a1", wa[1], 16'h0011);
    chk("t1 d1", wd[1], 32'hDEADBEEF);
    chk("t1 ntx", txq.size(), 1);
    chk("t1 tx", txq[0], 8'h06);
    chk("t1 err", errs, 0);
    chk("t1 hold", cpu_hold, 1);
    f[13] = 8'h38;
    clear(); send_f(); settle();
    chk("t2 nwr", wa.size(), 2);
    chk("t2 d1", wd[1], 32'hDEADBEEF);
    chk("t2 ntx", txq.size(), 1);
    chk("t2 tx", txq[0], 8'h15);
    chk("t2 err", errs, 1);
    f = '{8'h55, 8'h07, 8'h00};
    clear(); send_f(); settle();
    chk("badcmd tx", txq[0], 8'h15);
    chk("badcmd ntx", txq.size(), 1);
    f = '{8'h55, 8'h02, 8'h03};
    clear(); send_f(); settle();
    chk("t3 badrun tx", txq[0], 8'h15);
    chk("t3 badrun hold", cpu_hold, 1);
    f = '{8'h00, 8'hAA, 8'h55, 8'h02, 8'h02};
    clear(); send_f(); settle();
    chk("t3 run ntx", txq.size(), 1);
    chk("t3 run tx", txq[0], 8'h06);
    chk("t3 run hold", cpu_hold, 0);
    chk("t3 run err", errs, 0);
    rst = 1; repeat (2) @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("rst hold again", cpu_hold, 1);
    f = '{8'h55, 8'h01, 8'h10};
    clear(); send_f();
    repeat (TO - 50) @(posedge clk);
    @(negedge clk);
    chk("t4 no early timeout", errs, 0);
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("t4 timeout err", errs, 1);
    chk("t4 timeout ntx", txq.size(), 0);
    f = '{8'h55, 8'h01, 8'h10, 8'h00, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h39};
    clear(); send_f(); settle();
    chk("t4 after tx", txq[0], 8'h06);
    chk("t4 after nwr", wa.size(), 2);
    f = '{8'h55, 8'h01, 8'hFF, 8'hFF, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h8B};
    clear(); send_f(); settle();
    chk("t5 nwr", wa.size(), 2);
    chk("t5 a0", wa[0], 16'hFFFF);
    chk("t5 d0", wd[0], 32'h44332211);
    chk("t5 a1", wa[1], 16'h0000);
    chk("t5 d1", wd[1], 32'h88776655);
    chk("t5 tx", txq[0], 8'h06);
    f = '{8'h55, 8'h01, 8'h20, 8'h00, 8'h00, 8'h21};
    clear(); send_f(); settle();
    chk("n0 nwr", wa.size(), 0);
    chk("n0 tx", txq[0], 8'h06);
    tx_busy = 1;
    f = '{8'h55, 8'h02, 8'h02};
    clear(); send_f();
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("t6 busy ntx", txq.size(), 0);
    @(posedge clk); #1 tx_busy = 0;
    settle();
    chk("t6 ntx", txq.size(), 1);
    chk("t6 tx", txq[0], 8'h06);
    chk("t6 hold", cpu_hold, 0);
    f = '{8'h55, 8'h01, 8'h10, 8'h00, 8'h02, 8'h78, 8'h56, 8'h34};
    clear(); send_f();
    rst = 1; repeat (2) @(posedge clk); #1 rst = 0;
    f = '{8'h12};
    send_f(); settle();
    chk("t6 rst nwr", wa.size(), 0);
    chk("t6 rst ntx", txq.size(), 0);
    chk("t6 rst hold", cpu_hold, 1);
    chk("busy viol", busy_viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
